// File: rtl/icache_controller_if.sv
// rtl/icache_controller_if.sv - fetch and memory-fill signal bundle for icache_controller
interface icache_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [DATA_WIDTH-1:0] fetch_addr_in;
    logic [ID_WIDTH-1:0]   fetch_id_in;
    logic                  fetch_valid_in;
    logic                  invalidate_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ID_WIDTH-1:0]   id_out;
    logic                  ready_out;
    logic                  stall_out;
    logic [DATA_WIDTH-1:0] mem_addr_out;
    logic                  mem_req_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_ready_in;

    // Core fetch stage plus instruction memory side
    modport master (
        output fetch_addr_in, fetch_id_in, fetch_valid_in, invalidate_in,
        output mem_data_in, mem_ready_in,
        input  data_out, id_out, ready_out, stall_out, mem_addr_out, mem_req_out
    );

    // Cache side
    modport slave (
        input  fetch_addr_in, fetch_id_in, fetch_valid_in, invalidate_in,
        input  mem_data_in, mem_ready_in,
        output data_out, id_out, ready_out, stall_out, mem_addr_out, mem_req_out
    );
endinterface

// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - direct-mapped read-only instruction cache with word-serial line fill
module icache_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                clk,
    input  logic                reset,
    icache_controller_if.slave  bus
);
    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = DATA_WIDTH - 2 - WB - IB;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;

    state_e                state_q, state_d;
    logic                  req_pending_q, req_pending_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ID_WIDTH-1:0]   req_id_q, req_id_d;
    logic [WB-1:0]         cnt_q, cnt_d;
    logic                  inval_seen_q, inval_seen_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_LINES][WORDS_PER_LINE];
    logic [TB-1:0]         tag_arr  [NUM_LINES];

    logic [WB-1:0] req_word;
    logic [IB-1:0] req_index;
    logic [TB-1:0] req_tag;
    logic          hit;
    logic          stall;
    logic          accept;
    logic          fill_beat;
    logic          last_beat;
    logic          unused_addr_bits;

    assign req_word         = req_addr_q[2 +: WB];
    assign req_index        = req_addr_q[2 + WB +: IB];
    assign req_tag          = req_addr_q[DATA_WIDTH-1 -: TB];
    assign unused_addr_bits = ^req_addr_q[1:0];

    assign hit       = valid_q[req_index] && (tag_arr[req_index] == req_tag);
    assign stall     = (state_q != IDLE) || (req_pending_q && !hit);
    assign accept    = bus.fetch_valid_in && !stall;
    assign fill_beat = (state_q == FILL) && bus.mem_ready_in;
    assign last_beat = fill_beat && (cnt_q == WB'(WORDS_PER_LINE - 1));

    assign bus.stall_out    = stall;
    assign bus.ready_out    = ready_q;
    assign bus.data_out     = data_q;
    assign bus.id_out       = id_q;
    assign bus.mem_req_out  = mem_req_q;
    assign bus.mem_addr_out = mem_addr_q;

    // Next-state: hit/miss resolution, line fill sequencing, response and request capture
    always_comb begin
        state_d       = state_q;
        req_pending_d = req_pending_q;
        req_addr_d    = req_addr_q;
        req_id_d      = req_id_q;
        cnt_d         = cnt_q;
        inval_seen_d  = inval_seen_q;
        valid_d       = valid_q;
        ready_d       = 1'b0;
        data_d        = data_q;
        id_d          = id_q;

        if (bus.invalidate_in) begin
            valid_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (req_pending_q) begin
                    if (hit) begin
                        ready_d       = 1'b1;
                        data_d        = data_arr[req_index][req_word];
                        id_d          = req_id_q;
                        req_pending_d = 1'b0;
                    end else begin
                        // The line is being overwritten, so it must not look valid meanwhile
                        valid_d[req_index] = 1'b0;
                        state_d            = FILL;
                        cnt_d              = '0;
                        inval_seen_d       = 1'b0;
                    end
                end
            end
            FILL: begin
                if (bus.invalidate_in) begin
                    inval_seen_d = 1'b1;
                end
                if (fill_beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        if (!inval_seen_q && !bus.invalidate_in) begin
                            valid_d[req_index] = 1'b1;
                        end
                        state_d = RESP;
                        ready_d = 1'b1;
                        id_d    = req_id_q;
                        // Earlier words are already in the array; the last one is still on the bus
                        data_d  = (req_word == cnt_q) ? bus.mem_data_in
                                                      : data_arr[req_index][req_word];
                    end
                end
            end
            RESP: begin
                req_pending_d = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            req_pending_d = 1'b1;
            req_addr_d    = bus.fetch_addr_in;
            req_id_d      = bus.fetch_id_in;
        end

        mem_req_d  = (state_d == FILL);
        mem_addr_d = (state_d == FILL) ? {req_tag, req_index, cnt_d, 2'b00} : mem_addr_q;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            req_pending_q <= 1'b0;
            req_addr_q    <= '0;
            req_id_q      <= '0;
            cnt_q         <= '0;
            inval_seen_q  <= 1'b0;
            valid_q       <= '0;
            ready_q       <= 1'b0;
            data_q        <= '0;
            id_q          <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_pending_q <= req_pending_d;
            req_addr_q    <= req_addr_d;
            req_id_q      <= req_id_d;
            cnt_q         <= cnt_d;
            inval_seen_q  <= inval_seen_d;
            valid_q       <= valid_d;
            ready_q       <= ready_d;
            data_q        <= data_d;
            id_q          <= id_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    // Data and tag storage, written only by the fill and never reset
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_arr[req_index][cnt_q] <= bus.mem_data_in;
        end
        if (last_beat) begin
            tag_arr[req_index] <= req_tag;
        end
    end
endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - self-checking bench for icache_controller
module tb_icache_controller;
    localparam int WPL = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        int          acc;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    int   mem_mode;
    int   resp_cnt;
    logic [31:0] last_data;
    logic [3:0]  last_id;

    exp_t        exp_q[$];
    logic [31:0] fill_q[$];
    logic [31:0] seen_addr[$];
    bit          mvalid [64];
    logic [21:0] mtag   [64];

    icache_controller_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    icache_controller #(
        .DATA_WIDTH(32), .ID_WIDTH(4), .NUM_LINES(64), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic void fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endfunction

    // Responses: order, data, id and latency against the model's expectation queue
    always @(negedge clk) begin
        if (bus.ready_out) begin
            resp_cnt++;
            last_data = bus.data_out;
            last_id   = bus.id_out;
            if (exp_q.size() == 0) begin
                fail("spurious_ready");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_data", 64'(bus.data_out), 64'(e.data));
                check("resp_id", 64'(bus.id_out), 64'(e.id));
                if (e.lat >= 0) check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    // Memory responder: every cycle or every third cycle, checking fill addresses
    int   slow_cnt;
    logic prev_req;
    logic prev_rdy;
    logic [31:0] prev_addr;
    always @(negedge clk) begin
        if (bus.mem_req_out) begin
            check("fill_stall", 64'(bus.stall_out), 64'd1);
            if (prev_req && !prev_rdy) check("mem_addr_stable", 64'(bus.mem_addr_out), 64'(prev_addr));
            slow_cnt++;
            if (mem_mode == 0 || (slow_cnt % 3) == 0) begin
                if (fill_q.size() == 0) begin
                    fail("spurious_mem_req");
                end else begin
                    check("mem_addr", 64'(bus.mem_addr_out), 64'(fill_q.pop_front()));
                end
                seen_addr.push_back(bus.mem_addr_out);
                bus.mem_data_in  = mem_fn(bus.mem_addr_out);
                bus.mem_ready_in = 1'b1;
            end else begin
                bus.mem_data_in  = 32'hDEAD_BEEF;
                bus.mem_ready_in = 1'b0;
            end
        end else begin
            bus.mem_ready_in = 1'b0;
            slow_cnt         = 0;
        end
        prev_req  = bus.mem_req_out;
        prev_rdy  = bus.mem_ready_in;
        prev_addr = bus.mem_addr_out;
    end

    task automatic fetch(input logic [31:0] a, input logic [3:0] id, output int stalls);
        exp_t        e;
        int          idx;
        logic [21:0] tg;
        bit          h;
        bus.fetch_addr_in  = a;
        bus.fetch_id_in    = id;
        bus.fetch_valid_in = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (bus.stall_out && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 200) begin
            fail("accept_timeout");
        end else begin
            idx = int'((a >> 4) & 32'd63);
            tg  = a[31:10];
            h   = mvalid[idx] && (mtag[idx] == tg);
            if (!h) begin
                mvalid[idx] = 1'b1;
                mtag[idx]   = tg;
                for (int w = 0; w < WPL; w++) fill_q.push_back({a[31:4], 4'(w * 4)});
            end
            e.data = mem_fn({a[31:2], 2'b00});
            e.id   = id;
            e.acc  = cyc + 1;
            e.lat  = h ? 1 : ((mem_mode == 0) ? 1 + WPL : -1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.fetch_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.stall_out || bus.mem_req_out) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int st0, st1, st2, n0, r0, w;

    initial begin
        cyc = 0; total = 0; bad = 0; mem_mode = 0; resp_cnt = 0;
        slow_cnt = 0; prev_req = 1'b0; prev_rdy = 1'b0; prev_addr = '0;
        last_data = '0; last_id = '0;
        clear_model();
        reset = 1'b0;
        bus.fetch_addr_in = '0; bus.fetch_id_in = '0; bus.fetch_valid_in = 1'b0;
        bus.invalidate_in = 1'b0; bus.mem_data_in = '0; bus.mem_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.ready_out), 64'd0);
        check("rst_stall", 64'(bus.stall_out), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req_out), 64'd0);
        check("rst_data", 64'(bus.data_out), 64'd0);
        check("rst_id", 64'(bus.id_out), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss
        n0 = seen_addr.size();
        fetch(32'h100, 4'd3, st0);
        drain();
        check("t1_data", 64'(last_data), 64'hA0);
        check("t1_id", 64'(last_id), 64'd3);
        check("t1_beats", 64'(seen_addr.size() - n0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            w = n0 + i;
            if (w < seen_addr.size()) check("t1_mem_addr", 64'(seen_addr[w]), 64'(32'h100 + 32'(i * 4)));
        end

        // Hit after fill
        n0 = seen_addr.size();
        fetch(32'h108, 4'd5, st0);
        drain();
        check("t2_data", 64'(last_data), 64'hA2);
        check("t2_id", 64'(last_id), 64'd5);
        check("t2_no_fill", 64'(seen_addr.size() - n0), 64'd0);

        // Back-to-back hits
        fetch(32'h100, 4'd1, st0);
        fetch(32'h104, 4'd2, st1);
        fetch(32'h10C, 4'd4, st2);
        drain();
        check("t3_stalls", 64'(st0 + st1 + st2), 64'd0);
        check("t3_data", 64'(last_data), 64'hA3);
        check("t3_id", 64'(last_id), 64'd4);

        // Conflict at the same index
        n0 = seen_addr.size();
        fetch(32'h500, 4'd6, st0);
        drain();
        fetch(32'h100, 4'd7, st0);
        drain();
        check("t4_beats", 64'(seen_addr.size() - n0), 64'd8);
        check("t4_data", 64'(last_data), 64'hA0);

        // Slow memory
        mem_mode = 1;
        fetch(32'h204, 4'd7, st0);
        drain();
        check("t5_data", 64'(last_data), 64'hE1);
        check("t5_id", 64'(last_id), 64'd7);

        // Invalidate during a fill
        fetch(32'h300, 4'd8, st0);
        n0 = 0;
        while (!bus.mem_req_out && n0 < 20) begin
            @(negedge clk);
            n0++;
        end
        if (n0 >= 20) fail("t6_fill_start_timeout");
        @(posedge clk); #1;
        bus.invalidate_in = 1'b1;
        @(posedge clk); #1;
        bus.invalidate_in = 1'b0;
        clear_model();
        drain();
        check("t6_data", 64'(last_data), 64'h120);
        n0 = seen_addr.size();
        fetch(32'h300, 4'd9, st0);
        drain();
        check("t6_refill_beats", 64'(seen_addr.size() - n0), 64'd4);

        // Invalidate coinciding with a hit
        n0 = seen_addr.size();
        fetch(32'h300, 4'd10, st0);
        bus.invalidate_in = 1'b1;
        @(posedge clk); #1;
        bus.invalidate_in = 1'b0;
        clear_model();
        drain();
        check("t6_hit_beats", 64'(seen_addr.size() - n0), 64'd0);
        check("t6_hit_id", 64'(last_id), 64'd10);
        n0 = seen_addr.size();
        fetch(32'h300, 4'd11, st0);
        drain();
        check("t6_after_inval_beats", 64'(seen_addr.size() - n0), 64'd4);

        // Reset during a fill
        fetch(32'h600, 4'd12, st0);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_ready", 64'(bus.ready_out), 64'd0);
        check("t6_rst_stall", 64'(bus.stall_out), 64'd0);
        check("t6_rst_mem_req", 64'(bus.mem_req_out), 64'd0);
        check("t6_rst_data", 64'(bus.data_out), 64'd0);
        check("t6_rst_id", 64'(bus.id_out), 64'd0);
        check("t6_rst_mem_addr", 64'(bus.mem_addr_out), 64'd0);
        exp_q.delete();
        fill_q.delete();
        clear_model();
        r0 = resp_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_resp_after_rst", 64'(resp_cnt - r0), 64'd0);
        @(posedge clk); #1;
        mem_mode = 0;
        n0 = seen_addr.size();
        fetch(32'h600, 4'd13, st0);
        drain();
        check("t6_rst_refill_beats", 64'(seen_addr.size() - n0), 64'd4);
        check("t6_rst_refill_data", 64'(last_data), 64'h1E0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
